// File: rtl/spart_if.sv
// rtl/spart_if.sv - host bus and status-flag bundle for the spart peripheral
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        input  rda,
        input  tbr
    );

    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        output rda,
        output tbr
    );
endinterface

// File: rtl/spart.sv
// rtl/spart.sv - bus-programmed 8N1 UART with 16x baud generator (optional even parity: SPART_PARITY_EN)
module spart #(
    parameter logic [15:0] RST_DIV = 16'd325
) (
    input  logic     clk,
    input  logic     rst,
    spart_if.slave   bus,
    inout  wire [7:0] databus,
    output logic     txd,
    input  logic     rxd
);

    // ---------------------------------------------------------------
    // Host bus decode
    // ---------------------------------------------------------------
    logic bus_wr, bus_rd;
    logic wr_tx, wr_dlo, wr_dhi, rd_rx, rd_st;

    assign bus_wr = bus.iocs & ~bus.iorw;
    assign bus_rd = bus.iocs &  bus.iorw;
    assign wr_tx  = bus_wr && (bus.ioaddr == 2'd0);
    assign wr_dlo = bus_wr && (bus.ioaddr == 2'd2);
    assign wr_dhi = bus_wr && (bus.ioaddr == 2'd3);
    assign rd_rx  = bus_rd && (bus.ioaddr == 2'd0);
    assign rd_st  = bus_rd && (bus.ioaddr == 2'd1);

    // ---------------------------------------------------------------
    // Baud generator: tick every div+1 clks
    // ---------------------------------------------------------------
    logic [15:0] div, div_new, baud_cnt;
    logic        tick;

    assign tick = (baud_cnt == 16'd0);

    // Merge a divisor byte write into the full value used for reload
    always_comb begin
        div_new = div;
        if (wr_dlo)
            div_new = {div[15:8], databus};
        else if (wr_dhi)
            div_new = {databus, div[7:0]};
    end

    // Divisor register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= RST_DIV;
        else if (wr_dlo || wr_dhi)
            div <= div_new;
    end

    // Down-counter; a divisor write restarts the period immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            baud_cnt <= RST_DIV;
        else if (wr_dlo || wr_dhi)
            baud_cnt <= div_new;
        else if (tick)
            baud_cnt <= div;
        else
            baud_cnt <= baud_cnt - 16'd1;
    end

    // ---------------------------------------------------------------
    // Transmitter
    // TX_LOAD holds the line idle until the next tick so the start bit
    // begins on a tick boundary and lasts exactly 16 ticks.
    // ---------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_START,
        TX_DATA,
`ifdef SPART_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_t;

    tx_state_t  tx_state, tx_next;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bcnt;
    logic [7:0] tx_sh;
    logic       tx_last;
`ifdef SPART_PARITY_EN
    logic       tx_par;
`endif

    assign tx_last = tick && (tx_tcnt == 4'd15);

    // TX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_next;
    end

    // TX next-state: each bit state lasts 16 ticks
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (wr_tx) tx_next = TX_LOAD;
            TX_LOAD:  if (tick) tx_next = TX_START;
            TX_START: if (tx_last) tx_next = TX_DATA;
`ifdef SPART_PARITY_EN
            TX_DATA:  if (tx_last && tx_bcnt == 3'd7) tx_next = TX_PAR;
            TX_PAR:   if (tx_last) tx_next = TX_STOP;
`else
            TX_DATA:  if (tx_last && tx_bcnt == 3'd7) tx_next = TX_STOP;
`endif
            TX_STOP:  if (tx_last) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX outputs: line level and buffer-ready flag
    always_comb begin
        txd = 1'b1;
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_sh[0];
`ifdef SPART_PARITY_EN
            TX_PAR:   txd = tx_par;
`endif
            default:  txd = 1'b1;
        endcase
        bus.tbr = (tx_state == TX_IDLE);
    end

    // TX datapath: byte capture, tick/bit counters, LSB-first shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sh   <= 8'h00;
            tx_tcnt <= 4'd0;
            tx_bcnt <= 3'd0;
`ifdef SPART_PARITY_EN
            tx_par  <= 1'b0;
`endif
        end else begin
            if (tx_state == TX_IDLE && wr_tx) begin
                tx_sh  <= databus;
`ifdef SPART_PARITY_EN
                tx_par <= ^databus;
`endif
            end else if (tx_state == TX_DATA && tx_last) begin
                tx_sh <= {1'b0, tx_sh[7:1]};
            end

            if (tx_state == TX_IDLE || tx_state == TX_LOAD)
                tx_tcnt <= 4'd0;
            else if (tick)
                tx_tcnt <= tx_tcnt + 4'd1;

            if (tx_state != TX_DATA)
                tx_bcnt <= 3'd0;
            else if (tx_last)
                tx_bcnt <= tx_bcnt + 3'd1;
        end
    end

    // ---------------------------------------------------------------
    // Receiver
    // ---------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef SPART_PARITY_EN
        RX_PAR,
`endif
        RX_STOP
    } rx_state_t;

    rx_state_t  rx_state, rx_next;
    logic       rx_meta, rx_s;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bcnt;
    logic [7:0] rx_sh;
    logic       rx_mid;
    logic       rx_ok, rx_bad, rx_perr_hit;

    // Start check lands 8 ticks in; every later sample is 16 ticks on
    assign rx_mid = tick && ((rx_state == RX_START) ? (rx_tcnt == 4'd7)
                                                     : (rx_tcnt == 4'd15));

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rx_state <= RX_IDLE;
        else
            rx_state <= rx_next;
    end

    // RX next-state: returns to idle right after the stop sample
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (tick && !rx_s) rx_next = RX_START;
            RX_START: if (rx_mid) rx_next = rx_s ? RX_IDLE : RX_DATA;
`ifdef SPART_PARITY_EN
            RX_DATA:  if (rx_mid && rx_bcnt == 3'd7) rx_next = RX_PAR;
            RX_PAR:   if (rx_mid) rx_next = RX_STOP;
`else
            RX_DATA:  if (rx_mid && rx_bcnt == 3'd7) rx_next = RX_STOP;
`endif
            RX_STOP:  if (rx_mid) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX outputs: frame-complete and error strobes
    always_comb begin
        rx_ok       = 1'b0;
        rx_bad      = 1'b0;
        rx_perr_hit = 1'b0;
        if (rx_state == RX_STOP && rx_mid) begin
            rx_ok  = rx_s;
            rx_bad = !rx_s;
        end
`ifdef SPART_PARITY_EN
        if (rx_state == RX_PAR && rx_mid)
            rx_perr_hit = (rx_s != ^rx_sh);
`endif
    end

    // RX datapath: tick/bit counters and LSB-first shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_tcnt <= 4'd0;
            rx_bcnt <= 3'd0;
            rx_sh   <= 8'h00;
        end else begin
            if (rx_state == RX_IDLE || (rx_state == RX_START && rx_mid))
                rx_tcnt <= 4'd0;
            else if (tick)
                rx_tcnt <= rx_tcnt + 4'd1;

            if (rx_state != RX_DATA)
                rx_bcnt <= 3'd0;
            else if (rx_mid)
                rx_bcnt <= rx_bcnt + 3'd1;

            if (rx_state == RX_DATA && rx_mid)
                rx_sh <= {rx_s, rx_sh[7:1]};
        end
    end

    // ---------------------------------------------------------------
    // Receive buffer and status flags; a new byte wins over a read clear
    // ---------------------------------------------------------------
    logic [7:0] rx_buf;
    logic       rda, ferr, perr;

    // Buffer, data-available and framing-error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf <= 8'h00;
            rda    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (rx_ok)
                rx_buf <= rx_sh;

            if (rx_ok)
                rda <= 1'b1;
            else if (rd_rx)
                rda <= 1'b0;

            if (rx_bad)
                ferr <= 1'b1;
            else if (rd_st)
                ferr <= 1'b0;
        end
    end

`ifdef SPART_PARITY_EN
    // Parity-error flag, cleared by a status read
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perr <= 1'b0;
        else if (rx_perr_hit)
            perr <= 1'b1;
        else if (rd_st)
            perr <= 1'b0;
    end
`else
    assign perr = 1'b0;
`endif

    assign bus.rda = rda;

    // ---------------------------------------------------------------
    // Read mux and tri-state driver
    // ---------------------------------------------------------------
    logic [7:0] rd_data;

    // Combinational register read; divisor bytes read as zero
    always_comb begin
        rd_data = 8'h00;
        case (bus.ioaddr)
            2'd0:    rd_data = rx_buf;
            2'd1:    rd_data = {4'b0000, perr, ferr, rda, bus.tbr};
            default: rd_data = 8'h00;
        endcase
    end

    assign databus = (bus_rd && !rst) ? rd_data : 8'bzzzz_zzzz;

endmodule

// File: doc/spart.md
# spart

Special-purpose asynchronous receiver/transmitter: the bus-slave peripheral that a processor-side driver programs and polls over an 8-bit tri-state databus. It holds a 16-bit baud divisor written by the host and generates a 16x oversampling tick from it. It serialises host-written bytes onto txd as 8N1 frames and deserialises 8N1 frames from rxd into a receive buffer. Status flags tbr and rda are exported as dedicated wires and are also readable over the bus.

## Interface

Parameters:
- RST_DIV, 16'd325, divisor loaded at reset (9600 baud at 50 MHz).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- iocs  in  1  chip select; bus access occurs only when high.
- iorw  in  1  1 = host read, 0 = host write.
- ioaddr  in  2  register select.
- databus  inout  8  shared data bus; driven by spart only during selected reads, otherwise Z.
- rda  out  1  receive data available.
- tbr  out  1  transmit buffer ready.
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, asynchronous.

## Operation

- Register map:
  - 00: read RX buffer / write TX byte.
  - 01: read status / writes ignored.
  - 10: divisor low byte (write only).
  - 11: divisor high byte (write only).
  - Reads of 10/11 return 8'h00.
- Status byte: bit0 tbr, bit1 rda, bit2 ferr, bit3 perr (0 without macro), bits7:4 = 0.
- Baud generator:
  - 16-bit down-counter; a one-clk `tick` fires when it reaches 0, then it reloads the divisor.
  - Period is divisor+1 clks, so bit time = 16*(divisor+1) clks. Divisor 0 gives a tick every clk.
  - Any divisor write updates that byte at the clk edge and reloads the counter with the new full value.
- TX FSM (IDLE, START, DATA, [PARITY], STOP):
  - A write to 00 while tbr=1 loads the shifter and moves IDLE -> START. tbr falls on the next clk.
  - Each state lasts 16 ticks. DATA shifts LSB first, 8 bits.
  - When STOP ends: IDLE, tbr=1.
  - A write to 00 while tbr=0 is dropped, with no effect on the frame in flight.
- RX FSM (IDLE, START, DATA, [PARITY], STOP):
  - rxd passes through a 2-flop synchroniser.
  - IDLE -> START on synchronised rxd=0 at a tick.
  - START samples at tick count 8. If the sample is 1 (false start), return to IDLE with no flag change.
  - DATA samples each bit at its 16-tick midpoint, LSB first.
  - STOP midpoint sample = 1: byte -> RX buffer, rda=1.
  - STOP midpoint sample = 0: byte discarded, ferr=1.
  - The FSM returns to IDLE right after the STOP sample.
- Overrun: a new valid byte overwrites the RX buffer even when rda=1. No separate flag.
- Bus read of 00 with iocs=1: clears rda at that clk edge.
- Bus read of 01 with iocs=1: clears ferr and perr at that clk edge, after the pre-clear value has been returned.
- Simultaneous RX completion and host read of 00 in the same clk: new byte stored, rda stays 1.

## Timing

- Reset values:
  - txd=1, tbr=1, rda=0, ferr=0, perr=0.
  - divisor=RST_DIV, baud counter=RST_DIV.
  - Both FSMs IDLE, RX buffer 8'h00, databus Z.
- Reset mid-frame aborts immediately; txd returns high asynchronously.
- Read data is combinational from ioaddr whenever iocs=1 and iorw=1, valid in the same cycle. The driver releases the bus when the condition drops.
- Writes are captured on the clk edge with iocs=1 and iorw=0.
- txd start edge: the first tick after the write edge. Frame length is 10 bit times (11 with parity).
- rda rises 1 clk after the STOP-midpoint tick.
- rxd-to-FSM latency: 2 clks (synchroniser).

## Configuration

- SPART_PARITY_EN defined:
  - TX inserts an even-parity bit between DATA and STOP.
  - RX samples a parity bit; on mismatch it sets perr and still stores the byte with rda=1.
  - Status bit3 = perr.
- Undefined: 8N1 only, no PARITY states, status bit3 = 0.

## Test plan

- Reset: assert rst mid-TX frame -> txd=1, tbr=1, rda=0, databus Z in the same cycle; status read returns 8'h01.
- Divisor 16'h0001 via writes 10<-8'h01, 11<-8'h00; write 00<-8'hA5 -> txd start bit lasts 32 clks, data bits 1,0,1,0,0,1,0,1 LSB first, stop high; tbr=1 after 320 clks.
- Divisor 1: drive an rxd frame for 8'h3C -> rda=1 after the stop midpoint; read 00 returns 8'h3C and rda=0 the next clk.
- rxd low pulse of 4 bit-ticks -> false start, no rda, ferr=0.
- Frame with stop bit 0 -> rda stays 0; status read returns ferr=1, and the next status read shows ferr=0.
- Write 00<-8'h11 during an active frame -> ignored, txd frame unchanged; with SPART_PARITY_EN, byte 8'h07 sends parity bit 1.
